// File: rtl/mc_core_ctrl_pkg.sv
// rtl/mc_core_ctrl_pkg.sv - shared constants for the multi-cycle RV32I control core
package mc_core_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEMORY  = 3'd3,
        S_WRITEB  = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ALU codes are plain 4-bit values so that the unused codes 11-15 stay representable
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [3:0] MCT_IDLE  = 4'd0;
    localparam logic [3:0] MCT_IREAD = 4'd1;
    localparam logic [3:0] MCT_LOAD  = 4'd2;
    localparam logic [3:0] MCT_STORE = 4'd3;

    localparam logic [1:0] WB_MEM    = 2'd0;
    localparam logic [1:0] WB_ANS    = 2'd1;
    localparam logic [1:0] WB_PCREL  = 2'd2;

    localparam logic [1:0] RF_IDLE   = 2'b00;
    localparam logic [1:0] RF_LATCH  = 2'b10;
    localparam logic [1:0] RF_WRITE  = 2'b01;

    // R-type and I-ALU share one funct3 table; only R may select SUB
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt, input logic allow_sub);
        logic [3:0] sel;
        case (f3)
            3'd0:    sel = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'd1:    sel = ALU_SLL;
            3'd2:    sel = ALU_SLT;
            3'd3:    sel = ALU_SLTU;
            3'd4:    sel = ALU_XOR;
            3'd5:    sel = alt ? ALU_SRA : ALU_SRL;
            3'd6:    sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mc_core_ctrl_if.sv
// rtl/mc_core_ctrl_if.sv - datapath-facing bus of the control core
interface mc_core_ctrl_if;
    logic [31:0] ins;
    logic        zero;
    logic        neg;
    logic        uneg;
    logic [31:0] a;
    logic [31:0] b_op;
    logic [31:0] ans;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [19:0] imm;
    logic        pcif_en;
    logic        npc_en;
    logic [1:0]  rf_ctl;
    logic        mux0;
    logic        mux1;
    logic [1:0]  mux2;
    logic        mux3;
    logic        mux4;
    logic [3:0]  mct;

    modport master (
        input  ins, zero, neg, uneg, a, b_op,
        output ans, op, rd, rs1, rs2, imm, pcif_en, npc_en, rf_ctl,
               mux0, mux1, mux2, mux3, mux4, mct
    );

    modport slave (
        output ins, zero, neg, uneg, a, b_op,
        input  ans, op, rd, rs1, rs2, imm, pcif_en, npc_en, rf_ctl,
               mux0, mux1, mux2, mux3, mux4, mct
    );
endinterface

// File: rtl/mc_core_ctrl_alu.sv
// rtl/mc_core_ctrl_alu.sv - combinational ALU with registered result
module mc_alu
    import mc_core_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  alu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] ans
);

    logic [31:0] res;

    // ALU function select; unused codes give zero
    always_comb begin
        res = '0;
        case (alu_op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_AND:   res = a & b;
            ALU_OR:    res = a | b;
            ALU_XOR:   res = a ^ b;
            ALU_SLL:   res = a << b[4:0];
            ALU_SRL:   res = a >> b[4:0];
            ALU_SRA:   res = $signed(a) >>> b[4:0];
            ALU_SLT:   res = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU:  res = {31'd0, a < b};
            ALU_PASSB: res = b;
            default:   res = '0;
        endcase
    end

    // result register, loaded only while the core is executing an ALU instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ans <= '0;
        else if (en)
            ans <= res;
    end

endmodule

// File: rtl/mc_core_ctrl.sv
// rtl/mc_core_ctrl.sv - decoder, control FSM and ALU of the multi-cycle core (optional CORE_STATE_DBG_EN)
module mc_core_ctrl
    import mc_core_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    mc_core_ctrl_if.master bus
`ifdef CORE_STATE_DBG_EN
    ,
    output logic [2:0]     dbg_state,
    output logic [2:0]     dbg_nxt
`endif
);

    state_t      state;
    state_t      nxt;
    logic [31:0] ir;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_r, is_i, is_load, is_store, is_branch;
    logic        is_lui, is_auipc, is_jal, is_jalr, known;
    logic        taken;
    logic [19:0] imm;
    logic [3:0]  alu_op;

    logic        pc_en, mux0, mux1, mux3, mux4;
    logic [1:0]  rf_ctl, mux2;
    logic [3:0]  mct;

    assign opc       = ir[6:0];
    assign f3        = ir[14:12];
    assign is_r      = (opc == OP_R);
    assign is_i      = (opc == OP_I);
    assign is_load   = (opc == OP_LOAD);
    assign is_store  = (opc == OP_STORE);
    assign is_branch = (opc == OP_BRANCH);
    assign is_lui    = (opc == OP_LUI);
    assign is_auipc  = (opc == OP_AUIPC);
    assign is_jal    = (opc == OP_JAL);
    assign is_jalr   = (opc == OP_JALR);
    assign known     = is_r | is_i | is_load | is_store | is_branch |
                       is_lui | is_auipc | is_jal | is_jalr;

    // branch condition from funct3 and the register-file compare flags
    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.neg;
            3'b101:  taken = ~bus.neg;
            3'b110:  taken = bus.uneg;
            3'b111:  taken = ~bus.uneg;
            default: taken = 1'b0;
        endcase
    end

    // raw immediate field per instruction format, left unextended
    always_comb begin
        imm = '0;
        if (is_i || is_load || is_jalr)
            imm = {8'd0, ir[31:20]};
        else if (is_store)
            imm = {8'd0, ir[31:25], ir[11:7]};
        else if (is_branch)
            imm = {8'd0, ir[31], ir[7], ir[30:25], ir[11:8]};
        else if (is_lui || is_auipc)
            imm = ir[31:12];
        else if (is_jal)
            imm = {ir[31], ir[19:12], ir[20], ir[30:21]};
    end

    // ALU operation; AUIPC/JAL use the PC-relative unit so ADD is a don't-care there
    always_comb begin
        alu_op = ALU_ADD;
        if (is_r)
            alu_op = alu_sel(f3, ir[30], 1'b1);
        else if (is_i)
            alu_op = alu_sel(f3, ir[30], 1'b0);
        else if (is_lui)
            alu_op = ALU_PASSB;
    end

    // per-state control outputs and next-state selection
    always_comb begin
        nxt    = S_FETCH;
        pc_en  = 1'b0;
        rf_ctl = RF_IDLE;
        mux0   = 1'b0;
        mux1   = 1'b0;
        mux2   = WB_MEM;
        mux3   = 1'b0;
        mux4   = 1'b0;
        mct    = MCT_IDLE;
        case (state)
            S_FETCH: begin
                mct  = MCT_IREAD;
                mux1 = 1'b1;
                nxt  = S_DECODE;
            end
            S_DECODE: begin
                rf_ctl = RF_LATCH;
                if (known) begin
                    nxt = S_EXECUTE;
                end else begin
                    pc_en = 1'b1;
                    nxt   = S_FETCH;
                end
            end
            S_EXECUTE: begin
                mux0 = is_i | is_load | is_store | is_jalr | is_lui;
                if (is_branch) begin
                    pc_en = 1'b1;
                    mux3  = taken;
                    nxt   = S_FETCH;
                end else if (is_load || is_store) begin
                    nxt = S_MEMORY;
                end else begin
                    nxt = S_WRITEB;
                end
            end
            S_MEMORY: begin
                if (is_load) begin
                    mct = MCT_LOAD;
                    nxt = S_WRITEB;
                end else begin
                    mct   = MCT_STORE;
                    pc_en = 1'b1;
                    nxt   = S_FETCH;
                end
            end
            S_WRITEB: begin
                rf_ctl = (ir[11:7] != 5'd0) ? RF_WRITE : RF_IDLE;
                pc_en  = 1'b1;
                if (is_load)
                    mux2 = WB_MEM;
                else if (is_auipc || is_jal || is_jalr)
                    mux2 = WB_PCREL;
                else
                    mux2 = WB_ANS;
                mux3 = is_jal;
                mux4 = is_jalr;
                nxt  = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end

    // state register and instruction capture on the edge leaving FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= nxt;
            if (state == S_FETCH)
                ir <= bus.ins;
        end
    end

    mc_alu u_alu (
        .clk    (clk),
        .rst    (rst),
        .en     ((state == S_EXECUTE) && !is_branch),
        .alu_op (alu_op),
        .a      (bus.a),
        .b      (bus.b_op),
        .ans    (bus.ans)
    );

    assign bus.op      = opc;
    assign bus.rd      = ir[11:7];
    assign bus.rs1     = ir[19:15];
    assign bus.rs2     = ir[24:20];
    assign bus.imm     = imm;
    assign bus.pcif_en = pc_en;
    assign bus.npc_en  = pc_en;
    assign bus.rf_ctl  = rf_ctl;
    assign bus.mux0    = mux0;
    assign bus.mux1    = mux1;
    assign bus.mux2    = mux2;
    assign bus.mux3    = mux3;
    assign bus.mux4    = mux4;
    assign bus.mct     = mct;

`ifdef CORE_STATE_DBG_EN
    assign dbg_state = state;
    assign dbg_nxt   = nxt;
`endif

endmodule

// File: tb/tb_mc_core_ctrl.sv
// tb/tb_mc_core_ctrl.sv - self-checking bench for mc_core_ctrl
module tb_mc_core_ctrl;

    typedef enum {C_R, C_I, C_LOAD, C_STORE, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR, C_UNK} cls_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

`ifdef CORE_STATE_DBG_EN
    logic [2:0] dbg_state;
    logic [2:0] dbg_nxt;
`endif

    mc_core_ctrl_if bus ();

    mc_core_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef CORE_STATE_DBG_EN
        ,
        .dbg_state (dbg_state),
        .dbg_nxt   (dbg_nxt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=0x%08h expected=0x%08h", tag, what, obs, exp);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] w);
        case (w[6:0])
            7'h33:   return C_R;
            7'h13:   return C_I;
            7'h03:   return C_LOAD;
            7'h23:   return C_STORE;
            7'h63:   return C_BR;
            7'h37:   return C_LUI;
            7'h17:   return C_AUIPC;
            7'h6F:   return C_JAL;
            7'h67:   return C_JALR;
            default: return C_UNK;
        endcase
    endfunction

    function automatic logic [6:0] opcode_of(input int idx);
        logic [6:0] t [10];
        t = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        return t[idx];
    endfunction

    function automatic logic [19:0] imm_of(input logic [31:0] w, input cls_t c);
        case (c)
            C_I, C_LOAD, C_JALR: return {8'd0, w[31:20]};
            C_STORE:             return {8'd0, w[31:25], w[11:7]};
            C_BR:                return {8'd0, w[31], w[7], w[30:25], w[11:8]};
            C_LUI, C_AUIPC:      return w[31:12];
            C_JAL:               return {w[31], w[19:12], w[20], w[30:21]};
            default:             return 20'd0;
        endcase
    endfunction

    // instruction semantics on the operands the datapath presents
    function automatic logic [31:0] alu_ref(input logic [31:0] w, input cls_t c, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b[4:0];
        if (c == C_LUI) return b;
        if (c == C_LOAD || c == C_STORE || c == C_JALR) return a + b;
        case (w[14:12])
            3'd0: return (c == C_R && w[30]) ? a + (~b + 1) : a + b;
            3'd1: return a << sh;
            3'd2: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            3'd3: return {31'd0, a < b};
            3'd4: return a ^ b;
            3'd5: return w[30] ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0)) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic n, input logic u);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return n;
            3'd5: return !n;
            3'd6: return u;
            3'd7: return !u;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction from FETCH back to FETCH and compares its observed
    // behaviour (length, writes, PC update, memory traffic, result) to the model.
    task automatic run(input string tag, input logic [31:0] w, input logic [31:0] av, input logic [31:0] bv,
                       input logic z, input logic n, input logic u);
        cls_t        c;
        int          cycles, wr, pcc, exp_cycles;
        logic [1:0]  wr_mux2, exp_mux2;
        logic        pm3, pm4, npc_ok, done, exp_wr, exp_m3;
        logic [15:0] mask, exp_mask;
        logic [19:0] imm_s;
        logic [4:0]  rd_s;

        bus.ins = w; bus.a = av; bus.b_op = bv;
        bus.zero = z; bus.neg = n; bus.uneg = u;
        c = classify(w);
        cycles = 1; wr = 0; pcc = 0; wr_mux2 = 2'd3; pm3 = 0; pm4 = 0;
        npc_ok = 1; done = 0; imm_s = '0; rd_s = '0;
        mask = 16'd0;
        mask[bus.mct] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.mct == 4'd1) begin
                done = 1;
                break;
            end
            cycles++;
            if (k == 0) begin
                imm_s = bus.imm;
                rd_s  = bus.rd;
            end
            mask[bus.mct] = 1'b1;
            if (bus.rf_ctl == 2'b01) begin
                wr++;
                wr_mux2 = bus.mux2;
            end
            if (bus.pcif_en) begin
                pcc++;
                pm3 = bus.mux3;
                pm4 = bus.mux4;
            end
            if (bus.npc_en !== bus.pcif_en) npc_ok = 0;
        end

        case (c)
            C_BR:    exp_cycles = 3;
            C_LOAD:  exp_cycles = 5;
            C_UNK:   exp_cycles = 2;
            default: exp_cycles = 4;
        endcase
        exp_wr   = !(c == C_BR || c == C_STORE || c == C_UNK) && (w[11:7] != 5'd0);
        exp_mux2 = (c == C_LOAD) ? 2'd0 : (c == C_R || c == C_I || c == C_LUI) ? 2'd1 : 2'd2;
        exp_m3   = (c == C_JAL) || (c == C_BR && br_taken(w[14:12], z, n, u));
        exp_mask = 16'h0003 | ((c == C_LOAD) ? 16'h0004 : 16'h0) | ((c == C_STORE) ? 16'h0008 : 16'h0);

        check(tag, "back_to_fetch", done, 1);
        check(tag, "cycles", cycles, exp_cycles);
        check(tag, "rf_writes", wr, exp_wr);
        if (exp_wr) check(tag, "mux2", wr_mux2, exp_mux2);
        check(tag, "pc_updates", pcc, 1);
        check(tag, "mux3", pm3, exp_m3);
        check(tag, "mux4", pm4, c == C_JALR);
        check(tag, "npc_eq_pcif", npc_ok, 1);
        check(tag, "mct_seen", mask, exp_mask);
        check(tag, "imm", imm_s, imm_of(w, c));
        check(tag, "rd", rd_s, w[11:7]);
        if (c inside {C_R, C_I, C_LUI, C_LOAD, C_STORE, C_JALR})
            check(tag, "ans", bus.ans, alu_ref(w, c, av, bv));
    endtask

    initial begin
        logic [31:0] w;
        int          idx;

        rst = 1'b1;
        bus.ins = '0; bus.a = '0; bus.b_op = '0;
        bus.zero = 0; bus.neg = 0; bus.uneg = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", "mct", bus.mct, 1);
        check("reset", "mux1", bus.mux1, 1);
        check("reset", "ans", bus.ans, 0);
        check("reset", "rf_ctl", bus.rf_ctl, 0);
        check("reset", "pcif_en", bus.pcif_en, 0);
        check("reset", "imm", bus.imm, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset", "decode_mct", bus.mct, 0);
        check("post_reset", "decode_rf_ctl", bus.rf_ctl, 2'b10);
        check("post_reset", "decode_pc_en", bus.pcif_en, 1);
        @(posedge clk); #1;
        check("post_reset", "fetch_mct", bus.mct, 1);

        run("addi", 32'h0050_0093, 32'd0, 32'd5, 0, 0, 0);
        run("sub",  32'h4020_8133, 32'd3, 32'd7, 0, 0, 0);
        run("beq_t", 32'h0020_8463, 32'd1, 32'd1, 1, 0, 0);
        run("beq_n", 32'h0020_8463, 32'd1, 32'd2, 0, 1, 1);
        run("lw",   32'h0040_a183, 32'h100, 32'd4, 0, 0, 0);
        run("sw",   32'h0030_a423, 32'h100, 32'd8, 0, 0, 0);
        run("unk",  32'hFFFF_FFFF, 32'd0, 32'd0, 0, 0, 0);
        run("jal",  32'h0080_00ef, 32'd0, 32'd0, 0, 0, 0);
        run("jalr", 32'h0000_80e7, 32'h40, 32'd0, 0, 0, 0);
        run("lui",  32'h1234_52b7, 32'd0, 32'h1234_5000, 0, 0, 0);
        run("auipc", 32'h0000_1317, 32'd0, 32'd0, 0, 0, 0);
        run("addi_x0", 32'h0010_0013, 32'd9, 32'd1, 0, 0, 0);
        run("srai", 32'h4030_d093, 32'h8000_0010, 32'd3, 0, 0, 0);

        // reset in the middle of a load: no memory access or write strobe follows
        bus.ins = 32'h0040_a183;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort", "mct", bus.mct, 1);
        check("abort", "rf_ctl", bus.rf_ctl, 0);
        check("abort", "pcif_en", bus.pcif_en, 0);
        check("abort", "ans", bus.ans, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort", "fetch_after", bus.mct, 1);

        for (int i = 0; i < 60; i++) begin
            w = $urandom;
            idx = $urandom_range(0, 9);
            w[6:0] = opcode_of(idx);
            run($sformatf("rand%0d", i), w, $urandom, ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40)),
                1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
